// File: rtl/minero_pkg.sv
// minero_pkg: shared definitions for the multi-lane nonce search engine.
//   state_t        - search FSM states (IDLE, SEARCH, DRAIN, DONE)
//   hit_compare    - difficulty test: the two most significant TARGET_W-wide
//                    fields of the hash must both be below the target
//   EXHAUST_NONCE  - nonce reported when the whole nonce space misses
//                    (truncate to NONCE_W at the point of use)
package minero_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DRAIN  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [63:0] EXHAUST_NONCE = '1;

   // Operands are zero-extended to 64 bits so that one function serves
   // every HASH_W/TARGET_W combination; both compares are unsigned.
   function automatic logic hit_compare(input logic [63:0] hash,
                                        input logic [63:0] target,
                                        input int          hash_w,
                                        input int          target_w);
      logic [63:0] mask;
      logic [63:0] hi;
      logic [63:0] lo;
      mask = (64'd1 << target_w) - 64'd1;
      hi   = (hash >> (hash_w - target_w)) & mask;
      lo   = (hash >> (hash_w - 2 * target_w)) & mask;
      return (hi < target) && (lo < target);
   endfunction

endpackage

// File: rtl/sistema_minero_multicanal_hash_lane.sv
// hash_lane: one micro-hash lane with a HASH_LAT-deep register pipeline.
// The valid and nonce tags travel alongside the hash so the top level can
// tell which nonce each result belongs to.
//   clk, reset     - clock and synchronous active-high reset
//   flush          - clears every valid bit in the pipeline
//   valid_in       - this cycle's lane input is a real nonce
//   nonce_in       - nonce evaluated by this lane
//   payload        - latched block header; the hash block is {payload, nonce}
//   valid_out      - hash_out/nonce_out carry a real result
//   nonce_out      - nonce tag of the result
//   hash_out       - registered micro-hash of {payload, nonce_out}
module hash_lane
   import minero_pkg::*;
#(
   parameter int NONCE_W   = 32,
   parameter int PAYLOAD_W = 96,
   parameter int HASH_W    = 24,
   parameter int HASH_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 valid_in,
   input  logic [NONCE_W-1:0]   nonce_in,
   input  logic [PAYLOAD_W-1:0] payload,
   output logic                 valid_out,
   output logic [NONCE_W-1:0]   nonce_out,
   output logic [HASH_W-1:0]    hash_out
);

   localparam int BLK_W  = PAYLOAD_W + NONCE_W;
   localparam int NCHUNK = (BLK_W + HASH_W - 1) / HASH_W;
   localparam int PAD_W  = NCHUNK * HASH_W;

   // Micro-hash core: rotate/xor/add round applied once per HASH_W-wide chunk
   // of the zero-padded block, plus two finishing rounds so that the nonce
   // (lowest chunk) reaches the most significant hash bits.
   function automatic logic [HASH_W-1:0] mix(input logic [HASH_W-1:0] h);
      logic [HASH_W-1:0] r;
      r = {h[HASH_W-6:0], h[HASH_W-1 -: 5]};
      return (r ^ (h >> 3)) + h;
   endfunction

   function automatic logic [HASH_W-1:0] micro_hash(input logic [BLK_W-1:0] blk);
      logic [PAD_W-1:0]  padded;
      logic [HASH_W-1:0] h;
      padded = PAD_W'(blk);
      h      = HASH_W'(32'h9e3779b9);
      for (int c = 0; c < NCHUNK; c++) begin
         h = mix(h ^ padded[c*HASH_W +: HASH_W]);
      end
      h = mix(mix(h));
      return h;
   endfunction

   logic                valid_pipe_reg [HASH_LAT];
   logic [NONCE_W-1:0]  nonce_pipe_reg [HASH_LAT];
   logic [HASH_W-1:0]   hash_pipe_reg  [HASH_LAT];

   genvar gi;
   generate
      for (gi = 0; gi < HASH_LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (reset || flush) begin
                  valid_pipe_reg[gi] <= 1'b0;
               end else begin
                  valid_pipe_reg[gi] <= valid_in;
               end
               nonce_pipe_reg[gi] <= nonce_in;
               hash_pipe_reg[gi]  <= micro_hash({payload, nonce_in});
            end
         end else begin : g_next
            always_ff @(posedge clk) begin
               if (reset || flush) begin
                  valid_pipe_reg[gi] <= 1'b0;
               end else begin
                  valid_pipe_reg[gi] <= valid_pipe_reg[gi-1];
               end
               nonce_pipe_reg[gi] <= nonce_pipe_reg[gi-1];
               hash_pipe_reg[gi]  <= hash_pipe_reg[gi-1];
            end
         end
      end
   endgenerate

   assign valid_out = valid_pipe_reg[HASH_LAT-1];
   assign nonce_out = nonce_pipe_reg[HASH_LAT-1];
   assign hash_out  = hash_pipe_reg[HASH_LAT-1];

endmodule

// File: rtl/sistema_minero_multicanal.sv
// sistema_minero_multicanal: multi-lane nonce search engine.
// Evaluates LANES consecutive nonces per cycle against a latched payload and
// reports the lowest hitting nonce, or exhaustion of the nonce space.
//   clk, reset  - clock and synchronous active-high reset
//   active      - level request: 1 = search, 0 = release/abort
//   payload     - block header, sampled on search start
//   target      - difficulty, sampled on search start
//   terminado   - search finished; held until active drops
//   encontrado  - with terminado: 1 = hit, 0 = exhausted
//   nonceOut    - winning nonce, all-ones on exhaustion
//   hashOut     - hash of nonceOut, 0 on exhaustion
//   intentos    - (only with SISTEMA_CONTADOR_EN defined) number of hashes
//                 whose results were evaluated in the current search
module sistema_minero_multicanal
   import minero_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int NONCE_W   = 32,
   parameter int PAYLOAD_W = 96,
   parameter int HASH_W    = 24,
   parameter int TARGET_W  = 8,
   parameter int HASH_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 active,
   input  logic [PAYLOAD_W-1:0] payload,
   input  logic [TARGET_W-1:0]  target,
   output logic                 terminado,
   output logic                 encontrado,
   output logic [NONCE_W-1:0]   nonceOut,
`ifdef SISTEMA_CONTADOR_EN
   output logic [HASH_W-1:0]    hashOut,
   output logic [NONCE_W:0]     intentos
`else
   output logic [HASH_W-1:0]    hashOut
`endif
);

   localparam int DCW = $clog2(HASH_LAT + 1) + 1;
   // Base of the final issue cycle: 2^NONCE_W - LANES without a 2^NONCE_W term.
   localparam logic [NONCE_W-1:0] LAST_BASE = {NONCE_W{1'b1}} - NONCE_W'(LANES - 1);

   state_t                state_reg, state_next;
   logic [NONCE_W-1:0]    base_reg;
   logic [PAYLOAD_W-1:0]  payload_reg;
   logic [TARGET_W-1:0]   target_reg;
   logic [DCW-1:0]        drain_cnt_reg;
   logic                  terminado_reg;
   logic                  encontrado_reg;
   logic [NONCE_W-1:0]    nonce_out_reg;
   logic [HASH_W-1:0]     hash_out_reg;

   logic                  lane_valid [LANES];
   logic [NONCE_W-1:0]    lane_nonce [LANES];
   logic [HASH_W-1:0]     lane_hash  [LANES];
   logic [LANES-1:0]      lane_hit;
   logic                  any_hit;
   logic [NONCE_W-1:0]    sel_nonce;
   logic [HASH_W-1:0]     sel_hash;
   logic                  issue;
   logic                  flush;
   logic                  last_issue;
   logic                  drain_over;

   assign issue      = (state_reg == SEARCH);
   // Anything outside an ongoing search (including the abort cycle) empties
   // the lanes, so no stale result can leak into the next search.
   assign flush      = !active || !(state_reg == SEARCH || state_reg == DRAIN);
   assign last_issue = (base_reg == LAST_BASE);
   // DRAIN waits HASH_LAT cycles for in-flight results, then one more
   // cycle to declare exhaustion.
   assign drain_over = (drain_cnt_reg == DCW'(HASH_LAT));

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         hash_lane #(
            .NONCE_W   (NONCE_W),
            .PAYLOAD_W (PAYLOAD_W),
            .HASH_W    (HASH_W),
            .HASH_LAT  (HASH_LAT)
         ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .valid_in  (issue),
            .nonce_in  (base_reg + NONCE_W'(gi)),
            .payload   (payload_reg),
            .valid_out (lane_valid[gi]),
            .nonce_out (lane_nonce[gi]),
            .hash_out  (lane_hash[gi])
         );

         assign lane_hit[gi] = lane_valid[gi] &&
                               hit_compare(64'(lane_hash[gi]), 64'(target_reg), HASH_W, TARGET_W);
      end
   endgenerate

   // All lanes of one result cycle carry consecutive nonces, so the lowest
   // hitting lane index is the lowest hitting nonce overall.
   always_comb begin
      sel_nonce = '0;
      sel_hash  = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (lane_hit[i]) begin
            sel_nonce = lane_nonce[i];
            sel_hash  = lane_hash[i];
         end
      end
      any_hit = |lane_hit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (active) state_next = SEARCH;
         SEARCH: begin
            if (!active)         state_next = IDLE;
            else if (any_hit)    state_next = DONE;
            else if (last_issue) state_next = DRAIN;
         end
         DRAIN: begin
            if (!active)         state_next = IDLE;
            else if (any_hit)    state_next = DONE;
            else if (drain_over) state_next = DONE;
         end
         DONE:    if (!active) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_reg       <= '0;
         payload_reg    <= '0;
         target_reg     <= '0;
         drain_cnt_reg  <= '0;
         terminado_reg  <= 1'b0;
         encontrado_reg <= 1'b0;
         nonce_out_reg  <= '0;
         hash_out_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (active) begin
                  payload_reg <= payload;
                  target_reg  <= target;
                  base_reg    <= '0;
               end
            end
            SEARCH: begin
               drain_cnt_reg <= '0;
               if (active) begin
                  base_reg <= base_reg + NONCE_W'(LANES);
                  if (any_hit) begin
                     terminado_reg  <= 1'b1;
                     encontrado_reg <= 1'b1;
                     nonce_out_reg  <= sel_nonce;
                     hash_out_reg   <= sel_hash;
                  end
               end
            end
            DRAIN: begin
               if (active) begin
                  drain_cnt_reg <= drain_cnt_reg + 1'b1;
                  if (any_hit) begin
                     terminado_reg  <= 1'b1;
                     encontrado_reg <= 1'b1;
                     nonce_out_reg  <= sel_nonce;
                     hash_out_reg   <= sel_hash;
                  end else if (drain_over) begin
                     terminado_reg  <= 1'b1;
                     encontrado_reg <= 1'b0;
                     nonce_out_reg  <= NONCE_W'(EXHAUST_NONCE);
                     hash_out_reg   <= '0;
                  end
               end
            end
            DONE: begin
               if (!active) begin
                  terminado_reg  <= 1'b0;
                  encontrado_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SISTEMA_CONTADOR_EN
   logic [NONCE_W:0] intentos_reg;

   // Every lane is valid in the same cycles, so lane 0 stands for all of them.
   always_ff @(posedge clk) begin
      if (reset) begin
         intentos_reg <= '0;
      end else if (state_reg == IDLE && active) begin
         intentos_reg <= '0;
      end else if ((state_reg == SEARCH || state_reg == DRAIN) && active && lane_valid[0]) begin
         intentos_reg <= intentos_reg + (NONCE_W+1)'(LANES);
      end
   end

   assign intentos = intentos_reg;
`endif

   assign terminado  = terminado_reg;
   assign encontrado = encontrado_reg;
   assign nonceOut   = nonce_out_reg;
   assign hashOut    = hash_out_reg;

endmodule

// File: tb/tb_sistema_minero_multicanal.sv
// Bench for sistema_minero_multicanal: two builds (4 lanes / latency 1 and
// 8 lanes / latency 2, both with an 8-bit nonce) share the same stimulus and
// are checked against a sequential first-hit search model.
module tb_sistema_minero_multicanal;

   localparam int NW = 8;
   localparam int PW = 96;
   localparam int HW = 24;
   localparam int TW = 8;
   localparam int LA = 4;
   localparam int HA = 1;
   localparam int LB = 8;
   localparam int HB = 2;

   logic          clk;
   logic          reset;
   logic          active;
   logic [PW-1:0] payload;
   logic [TW-1:0] target;

   logic          term_a, enc_a, term_b, enc_b;
   logic [NW-1:0] nonce_a, nonce_b;
   logic [HW-1:0] hash_a, hash_b;
`ifdef SISTEMA_CONTADOR_EN
   logic [NW:0]   int_a, int_b;
`endif

   int checks = 0;
   int errors = 0;

   sistema_minero_multicanal #(.LANES(LA), .NONCE_W(NW), .PAYLOAD_W(PW), .HASH_W(HW),
                               .TARGET_W(TW), .HASH_LAT(HA)) dut_a (
      .clk(clk), .reset(reset), .active(active), .payload(payload), .target(target),
      .terminado(term_a), .encontrado(enc_a), .nonceOut(nonce_a),
`ifdef SISTEMA_CONTADOR_EN
      .hashOut(hash_a), .intentos(int_a)
`else
      .hashOut(hash_a)
`endif
   );

   sistema_minero_multicanal #(.LANES(LB), .NONCE_W(NW), .PAYLOAD_W(PW), .HASH_W(HW),
                               .TARGET_W(TW), .HASH_LAT(HB)) dut_b (
      .clk(clk), .reset(reset), .active(active), .payload(payload), .target(target),
      .terminado(term_b), .encontrado(enc_b), .nonceOut(nonce_b),
`ifdef SISTEMA_CONTADOR_EN
      .hashOut(hash_b), .intentos(int_b)
`else
      .hashOut(hash_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference micro-hash in plain integer arithmetic on a 24-bit word.
   function automatic longint ref_mix(input longint h);
      longint m, r;
      m = (64'd1 << HW) - 1;
      r = ((h << 5) | (h >> (HW - 5))) & m;
      return ((r ^ (h >> 3)) + h) & m;
   endfunction

   function automatic longint ref_hash(input logic [PW-1:0] pl, input int n);
      logic [119:0] blk;
      longint       h, m;
      m   = (64'd1 << HW) - 1;
      blk = {16'd0, pl, 8'(n)};
      h   = 64'h9e3779b9 & m;
      for (int c = 0; c < 5; c++) begin
         h = ref_mix(h ^ longint'((blk >> (c * HW)) & 120'hffffff));
      end
      return ref_mix(ref_mix(h));
   endfunction

   function automatic bit ref_hit(input longint h, input int tg);
      return (((h >> 16) & 255) < tg) && (((h >> 8) & 255) < tg);
   endfunction

   // Sequential search from nonce 0 upward; first hit wins.
   task automatic ref_search(input logic [PW-1:0] pl, input int tg,
                             output bit found, output int n, output longint h);
      found = 0;
      n     = 255;
      h     = 0;
      for (int i = 0; i < 256; i++) begin
         if (!found && ref_hit(ref_hash(pl, i), tg)) begin
            found = 1;
            n     = i;
            h     = ref_hash(pl, i);
         end
      end
   endtask

   task automatic run_search(input string name, input logic [PW-1:0] pl, input logic [TW-1:0] tg);
      bit     found;
      int     n, lat_a, lat_b, exp_a, exp_b;
      longint h;
      ref_search(pl, int'(tg), found, n, h);
      exp_a = found ? (n / LA + HA + 1) : (256 / LA + HA + 1);
      exp_b = found ? (n / LB + HB + 1) : (256 / LB + HB + 1);
      @(negedge clk);
      payload = pl;
      target  = tg;
      active  = 1'b1;
      @(posedge clk);
      lat_a = -1;
      lat_b = -1;
      for (int cyc = 1; cyc <= 200 && (lat_a < 0 || lat_b < 0); cyc++) begin
         @(posedge clk);
         #1;
         if (lat_a < 0 && term_a) lat_a = cyc;
         if (lat_b < 0 && term_b) lat_b = cyc;
         if (cyc == 2) begin
            payload = {$urandom, $urandom, $urandom};
            target  = 8'($urandom);
         end
      end
      $display("search %s: tgt=%0h model found=%0d nonce=%0h hash=%0h | a: lat=%0d n=%0h | b: lat=%0d n=%0h",
               name, tg, found, n, h, lat_a, nonce_a, lat_b, nonce_b);
      check({name, "_lat_a"}, 64'(lat_a), 64'(exp_a));
      check({name, "_lat_b"}, 64'(lat_b), 64'(exp_b));
      check({name, "_enc_a"}, 64'(enc_a), 64'(found));
      check({name, "_enc_b"}, 64'(enc_b), 64'(found));
      check({name, "_nonce_a"}, 64'(nonce_a), 64'(n));
      check({name, "_nonce_b"}, 64'(nonce_b), 64'(n));
      check({name, "_hash_a"}, 64'(hash_a), 64'(h));
      check({name, "_hash_b"}, 64'(hash_b), 64'(h));
`ifdef SISTEMA_CONTADOR_EN
      check({name, "_intentos_a"}, 64'(int_a), found ? 64'((n / LA + 1) * LA) : 64'd256);
      check({name, "_intentos_b"}, 64'(int_b), found ? 64'((n / LB + 1) * LB) : 64'd256);
`endif
      // Holding active keeps DONE stable.
      repeat (3) @(posedge clk);
      #1;
      check({name, "_hold_term_a"}, 64'(term_a), 64'd1);
      check({name, "_hold_nonce_b"}, 64'(nonce_b), 64'(n));
      // Release: flags clear, result values stay.
      @(negedge clk);
      active = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_rel_term_a"}, 64'(term_a), 64'd0);
      check({name, "_rel_term_b"}, 64'(term_b), 64'd0);
      check({name, "_rel_enc_a"}, 64'(enc_a), 64'd0);
      check({name, "_rel_nonce_a"}, 64'(nonce_a), 64'(n));
      check({name, "_rel_hash_b"}, 64'(hash_b), 64'(h));
      @(posedge clk);
   endtask

   initial begin
      logic [PW-1:0] pl;
      bit            f;
      int            n;
      longint        h;

      reset   = 1'b1;
      active  = 1'b0;
      payload = '0;
      target  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_term_a", 64'(term_a), 64'd0);
      check("rst_enc_a", 64'(enc_a), 64'd0);
      check("rst_nonce_a", 64'(nonce_a), 64'd0);
      check("rst_hash_a", 64'(hash_a), 64'd0);
      check("rst_term_b", 64'(term_b), 64'd0);
      check("rst_nonce_b", 64'(nonce_b), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);

      run_search("given", 96'h397d9f2f40ca9e6c6b1f3324, 8'h0a);

      // Priority: a payload whose nonces 0 and 1 both hit at target ff.
      pl = {$urandom, $urandom, $urandom};
      for (int t = 0; t < 50 && !(ref_hit(ref_hash(pl, 0), 255) && ref_hit(ref_hash(pl, 1), 255)); t++) begin
         pl = {$urandom, $urandom, $urandom};
      end
      ref_search(pl, 255, f, n, h);
      check("prio_model_nonce0", 64'(n), 64'd0);
      run_search("prio", pl, 8'hff);

      run_search("exhaust", {$urandom, $urandom, $urandom}, 8'h00);

      for (int r = 0; r < 6; r++) begin
         run_search($sformatf("rand%0d", r), {$urandom, $urandom, $urandom},
                    8'($urandom_range(8'h60, 8'h08)));
      end

      // Reset in the middle of a (never-hitting) search.
      @(negedge clk);
      payload = {$urandom, $urandom, $urandom};
      target  = 8'h00;
      active  = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset  = 1'b1;
      active = 1'b0;
      @(posedge clk);
      #1;
      $display("midreset: a term=%0d n=%0h h=%0h | b term=%0d n=%0h h=%0h",
               term_a, nonce_a, hash_a, term_b, nonce_b, hash_b);
      check("midrst_term_a", 64'(term_a), 64'd0);
      check("midrst_nonce_a", 64'(nonce_a), 64'd0);
      check("midrst_hash_a", 64'(hash_a), 64'd0);
      check("midrst_enc_b", 64'(enc_b), 64'd0);
      check("midrst_nonce_b", 64'(nonce_b), 64'd0);
      check("midrst_hash_b", 64'(hash_b), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      check("post_rst_term_a", 64'(term_a), 64'd0);
      check("post_rst_term_b", 64'(term_b), 64'd0);

      run_search("after_rst", {$urandom, $urandom, $urandom}, 8'h30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sistema_minero_multicanal.md
# sistema_minero_multicanal

Parametrised multi-lane nonce search engine for the micro-hash mining datapath. Each cycle it evaluates LANES consecutive nonces against a latched payload through LANES pipelined hash lanes. It reports the lowest nonce whose hash meets the target, or reports exhaustion of the nonce space. It replaces the single-lane sequential search in the top-level mining system and keeps the same request/response style (level `active`, sticky `terminado`).

## Interface
- LANES, 4, parallel hash lanes; power of two, 1..16
- NONCE_W, 32, nonce width
- PAYLOAD_W, 96, payload width; hash block is {payload, nonce}
- HASH_W, 24, hash width
- TARGET_W, 8, target width; 2*TARGET_W <= HASH_W
- HASH_LAT, 1, cycles from lane input to registered hash, >= 1
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- active  in  1  level request; 1 = search, 0 = release/abort
- payload  in  PAYLOAD_W  block header; sampled on search start
- target  in  TARGET_W  difficulty; sampled on search start
- terminado  out  1  search finished (hit or exhausted); held until `active` drops
- encontrado  out  1  valid only with `terminado`: 1 = hit, 0 = exhausted
- nonceOut  out  NONCE_W  winning nonce, or all-ones on exhaustion
- hashOut  out  HASH_W  hash of nonceOut; 0 on exhaustion

## Operation
- FSM states are IDLE, SEARCH, DRAIN and DONE. After reset the FSM is in IDLE and all outputs are 0.
- **IDLE:** when `active`=1, latch `payload` and `target`, set base=0 and enter SEARCH.
- **SEARCH:** each cycle lane i receives nonce base+i. Base then advances by LANES.
  - The issue cycle with base = 2^NONCE_W − LANES is the last. After it, the FSM enters DRAIN.
- **Hit rule:** a hash hits when both conditions hold:
  - hash[HASH_W-1 -: TARGET_W] < target
  - hash[HASH_W-1-TARGET_W -: TARGET_W] < target
  - Both compares are unsigned.
- **Result arrival:** each lane result carries its nonce tag through a HASH_LAT-deep valid pipeline.
- **Hit selection:** on the first cycle with any valid hit, take the lowest-index hitting lane. That lane holds the lowest nonce overall.
  - Latch its nonce and hash, set encontrado=1, and enter DONE.
  - Discard all in-flight results.
- **DRAIN:** stop issuing and wait HASH_LAT cycles for in-flight results.
  - A hit during DRAIN ends the search as above.
  - If no hit occurs, set encontrado=0, nonceOut=all-ones, hashOut=0, and enter DONE.
- **DONE:** terminado=1 and outputs stay stable. When `active`=0, enter IDLE, clear terminado and clear encontrado. nonceOut and hashOut hold their values.
- **Abort:** `active`=0 in SEARCH or DRAIN returns to IDLE next cycle.
  - Flush the valid pipeline.
  - terminado stays 0 and the other outputs are unchanged.
- **Input changes:** changes on payload or target during SEARCH are ignored.
- **Reset:** reset asserted in any state returns to IDLE, clears all outputs and flushes the valid pipeline, with priority over everything.
- **Nonce arithmetic:** NONCE_W bits, no wrap past the last nonce. Target width compares are unsigned.

## Timing
- IDLE→SEARCH on the first edge with `active`=1. Issue cycle k (k=0 in the first SEARCH cycle) carries nonces k*LANES .. k*LANES+LANES-1.
- Results of issue cycle k are valid in cycle k+HASH_LAT. terminado rises at edge k+HASH_LAT+1 after SEARCH entry.
- Exhaustion: terminado rises 2^NONCE_W/LANES + HASH_LAT + 1 cycles after SEARCH entry.
- Throughput: LANES hashes per cycle, with no bubbles in SEARCH.
- Re-arm: `active` must be low for at least 1 cycle between searches. Holding `active` high in DONE keeps DONE.

## Configuration
- SISTEMA_CONTADOR_EN
  - Defined: adds output port `intentos` [NONCE_W:0]. It counts hashes whose results were evaluated (valid lanes observed), clears on search start and on reset, and holds in DONE.
  - Undefined: the port and counter do not exist. All other behaviour is identical.

## Structure
- Shared package `minero_pkg`:
  - FSM state typedef (IDLE, SEARCH, DRAIN, DONE)
  - hit-compare function (hash, target)
  - exhaustion nonce constant
- Sub-module `hash_lane` (instantiated LANES times):
  - wraps the team's micro-hash core with a HASH_LAT-stage register pipeline
  - carries the valid and nonce tags alongside
  - outputs valid, nonce and hash
- Top level contains the FSM, nonce base counter, priority select across lanes, and result registers.

## Test plan
- Reset mid-SEARCH (NONCE_W=32, target 8'h0a) → next cycle state IDLE, terminado=0, nonceOut=0, hashOut=0, no stale hit after release.
- payload 96'h397d9f2f40ca9e6c6b1f3324, target 8'h0a, LANES=4 → terminado with encontrado=1; nonceOut equals the scoreboard's sequential first hit; hashOut matches the model; terminado latency = (nonceOut/4)+HASH_LAT+1.
- Same payload and target with LANES=1, 2, 4 and 8 → identical nonceOut and hashOut across all builds.
- NONCE_W=8, target 8'h00 (never hits) → after 64+HASH_LAT+1 cycles (LANES=4): terminado=1, encontrado=0, nonceOut=8'hff, hashOut=0; `intentos`=256 with SISTEMA_CONTADOR_EN defined.
- target 8'hff with a payload whose nonces 0 and 1 both hit → nonceOut=0, showing lowest-lane priority.
- `active` dropped in DONE, then raised with a new payload → prior outputs held in IDLE; new search starts from nonce 0; terminado low for at least 1 cycle between searches.
